// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared FSM state type and default sync pattern for the 1011 frame link
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int         DEF_SYNC_W   = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_frame_tx_1011_if.sv
// rtl/seq_frame_tx_1011_if.sv - payload valid/ready handshake into the frame transmitter
interface seq_frame_tx_1011_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-in serial-out shift register, MSB presented first
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         q_msb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift_en) begin
      sr <= sr << 1;
    end
  end

  assign q_msb = sr[W-1];
endmodule

// File: rtl/seq_frame_tx_1011.sv
// rtl/seq_frame_tx_1011.sv - serial frame transmitter: sync pattern, MSB-first payload, idle gap
module seq_frame_tx_1011
  import seq_det_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
  parameter int                GAP      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_frame_tx_1011_if.slave   s_if,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 sync_flag,
  output logic                 frame_done
);
  localparam int MAXV = max3(SYNC_W, DATA_W, GAP);
  localparam int CW   = $clog2(MAXV + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [SYNC_W-1:0] pat_sh;
  logic              accept;
  logic              shift_en;
  logic              q_msb;

  assign s_if.data_ready = (state == ST_IDLE);
  assign accept          = s_if.data_valid && s_if.data_ready;
  // Outputs are produced one edge ahead, so the first payload bit leaves as SYNC ends.
  assign shift_en        = ((state == ST_SYNC) && (cnt == '0)) ||
                           ((state == ST_DATA) && (cnt != '0));
  assign pat_sh          = SYNC_PAT >> (cnt - 1'b1);

  piso_shift #(.W(DATA_W)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shift_en),
    .d        (s_if.data_in),
    .q_msb    (q_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      sync_flag  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (accept) begin
            state     <= ST_SYNC;
            cnt       <= CW'(SYNC_W - 1);
            ser_out   <= SYNC_PAT[SYNC_W-1];
            ser_valid <= 1'b1;
            sync_flag <= 1'b1;
          end else begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            sync_flag <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (cnt != '0) begin
            cnt     <= cnt - 1'b1;
            ser_out <= pat_sh[0];
          end else begin
            state      <= ST_DATA;
            cnt        <= CW'(DATA_W - 1);
            ser_out    <= q_msb;
            sync_flag  <= 1'b0;
            frame_done <= (DATA_W == 1);
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt        <= cnt - 1'b1;
            ser_out    <= q_msb;
            frame_done <= (cnt == CW'(1));
          end else begin
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (GAP > 0) begin
              state <= ST_GAP;
              cnt   <= CW'(GAP - 1);
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_frame_tx_1011.sv
// tb/tb_seq_frame_tx_1011.sv - directed checks of frame timing, data capture, reset abort, GAP=0 variant
module tb_seq_frame_tx_1011;
  logic clk = 1'b0;
  logic reset;
  logic ser_out, ser_valid, sync_flag, frame_done;
  logic ser_out_b, ser_valid_b, sync_flag_b, frame_done_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_frame_tx_1011_if #(.DATA_W(8)) if_a ();
  seq_frame_tx_1011_if #(.DATA_W(4)) if_b ();

  seq_frame_tx_1011 dut_a (
    .clk        (clk),
    .reset      (reset),
    .s_if       (if_a),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .sync_flag  (sync_flag),
    .frame_done (frame_done)
  );

  seq_frame_tx_1011 #(.DATA_W(4), .GAP(0)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .s_if       (if_b),
    .ser_out    (ser_out_b),
    .ser_valid  (ser_valid_b),
    .sync_flag  (sync_flag_b),
    .frame_done (frame_done_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Caller has offered a word in cycle 0; walks cycles 1..15 of one frame.
  task automatic frame_chk(input string name, input logic [11:0] bits, input int chg_cyc,
                           input logic [7:0] chg_d, input logic keep_v);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) if_a.data_valid = keep_v;
      if (k == chg_cyc) if_a.data_in = chg_d;
      chk($sformatf("%s_ser_out_c%0d", name, k), ser_out, (k <= 12) ? bits[12-k] : 1'b0);
      chk($sformatf("%s_ser_valid_c%0d", name, k), ser_valid, (k <= 12));
      chk($sformatf("%s_sync_flag_c%0d", name, k), sync_flag, (k <= 4));
      chk($sformatf("%s_frame_done_c%0d", name, k), frame_done, (k == 12));
      chk($sformatf("%s_data_ready_c%0d", name, k), if_a.data_ready, (k == 15));
    end
  endtask

  initial begin
    logic [11:0] a5_bits;
    logic [7:0]  b_bits;
    a5_bits = 12'b1011_1010_0101;
    b_bits  = 8'b1011_1001;

    reset           = 1'b1;
    if_a.data_in    = 8'hA5;
    if_a.data_valid = 1'b1;
    if_b.data_in    = 4'h0;
    if_b.data_valid = 1'b0;

    // 1: reset held three cycles with data offered
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_ser_out_%0d", k), ser_out, 1'b0);
      chk($sformatf("rst_ser_valid_%0d", k), ser_valid, 1'b0);
    end
    reset           = 1'b0;
    if_a.data_valid = 1'b0;
    tick();
    chk("post_rst_data_ready", if_a.data_ready, 1'b1);
    chk("post_rst_ser_valid", ser_valid, 1'b0);
    chk("post_rst_b_data_ready", if_b.data_ready, 1'b1);

    // 2: single A5 frame
    if_a.data_in    = 8'hA5;
    if_a.data_valid = 1'b1;
    frame_chk("a5", a5_bits, 1, 8'hA5, 1'b0);

    // 3: valid held, FF then 00 back to back
    if_a.data_in    = 8'hFF;
    if_a.data_valid = 1'b1;
    frame_chk("ff", 12'b1011_1111_1111, 1, 8'h00, 1'b1);
    frame_chk("z00", 12'b1011_0000_0000, 1, 8'h00, 1'b0);

    // 4: data_in disturbed after acceptance
    if_a.data_in    = 8'hA5;
    if_a.data_valid = 1'b1;
    frame_chk("late_chg", a5_bits, 3, 8'h00, 1'b0);

    // 5: reset during cycle 7 abandons the frame
    if_a.data_in    = 8'hA5;
    if_a.data_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) if_a.data_valid = 1'b0;
      chk($sformatf("abort_ser_out_c%0d", k), ser_out, a5_bits[12-k]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ser_out_c8", ser_out, 1'b0);
    chk("abort_ser_valid_c8", ser_valid, 1'b0);
    for (int k = 9; k <= 14; k++) begin
      tick();
      chk($sformatf("abort_frame_done_c%0d", k), frame_done, 1'b0);
      chk($sformatf("abort_ser_valid_c%0d", k), ser_valid, 1'b0);
    end
    if_a.data_in    = 8'hA5;
    if_a.data_valid = 1'b1;
    frame_chk("after_abort", a5_bits, 1, 8'hA5, 1'b0);

    // 6: GAP=0, DATA_W=4, back-to-back 4'h9 with valid held
    if_b.data_in    = 4'h9;
    if_b.data_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      int pos;
      tick();
      pos = (k - 1) % 9;
      chk($sformatf("g0_ser_out_c%0d", k), ser_out_b, (pos < 8) ? b_bits[7-pos] : 1'b0);
      chk($sformatf("g0_ser_valid_c%0d", k), ser_valid_b, (pos < 8));
      chk($sformatf("g0_sync_flag_c%0d", k), sync_flag_b, (pos < 4));
      chk($sformatf("g0_frame_done_c%0d", k), frame_done_b, (pos == 7));
      chk($sformatf("g0_data_ready_c%0d", k), if_b.data_ready, (pos == 8));
    end
    if_b.data_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
